fetch_unit: RTL and testbench

Instruction-fetch stage of the RV64 core, directly upstream of decode. Holds the architectural fetch PC and issues one 32-bit instruction request at a time on the instruction bus. Delivers each returned instruction to decode as a single-cycle `fetch_valid` pulse, with `reg_fetch_ins` and `reg_fetch_pc` held stable until the next delivery. Handles sequential advance, branch/trap redirects, global stall, and misaligned PCs.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the RV64 core.
// Keeps the fetch PC, issues one 32-bit instruction request at a time and
// hands each returned instruction to decode as a one-cycle fetch_valid pulse.
// Misaligned PCs never reach the bus; they are delivered as fault entries.

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        fetch_next,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        fetch_valid,
    output logic [31:0] reg_fetch_ins,
    output logic [63:0] reg_fetch_pc,
    output logic        fetch_err,
    output logic [63:0] fetch_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic        kill_q, kill_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] reg_fetch_ins_q, reg_fetch_ins_d;
    logic [63:0] reg_fetch_pc_q, reg_fetch_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [63:0] fetch_count_q, fetch_count_d;

    // Next-state logic: PC sequencing, request handling, response filtering and delivery.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        kill_d          = kill_q;
        fetch_valid_d   = 1'b0;
        reg_fetch_ins_d = reg_fetch_ins_q;
        reg_fetch_pc_d  = reg_fetch_pc_q;
        fetch_err_d     = fetch_err_q;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (!stall) begin
                    if (pc_q[1:0] == 2'b00) begin
                        req_addr_d = pc_q;
                        state_d    = REQ;
                    end else begin
                        reg_fetch_pc_d  = pc_q;
                        reg_fetch_ins_d = NOP;
                        fetch_err_d     = 1'b1;
                        fetch_valid_d   = 1'b1;
                        state_d         = HOLD;
                    end
                end
            end
            REQ: begin
                if (iresp_data_ok) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                        if (redirect_valid) begin
                            pc_d = redirect_pc;
                        end
                    end else begin
                        reg_fetch_ins_d = iresp_data;
                        reg_fetch_pc_d  = req_addr_q;
                        fetch_err_d     = 1'b0;
                        fetch_valid_d   = 1'b1;
                        state_d         = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = IDLE;
                end else if (fetch_next) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fetch_count_d = fetch_count_q + {63'd0, fetch_valid_d};
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            req_addr_q      <= RESET_PC;
            kill_q          <= 1'b0;
            fetch_valid_q   <= 1'b0;
            reg_fetch_ins_q <= NOP;
            reg_fetch_pc_q  <= 64'd0;
            fetch_err_q     <= 1'b0;
            fetch_count_q   <= 64'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_addr_q      <= req_addr_d;
            kill_q          <= kill_d;
            fetch_valid_q   <= fetch_valid_d;
            reg_fetch_ins_q <= reg_fetch_ins_d;
            reg_fetch_pc_q  <= reg_fetch_pc_d;
            fetch_err_q     <= fetch_err_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign ireq_valid    = (state_q == REQ);
    assign ireq_addr     = req_addr_q;
    assign fetch_valid   = fetch_valid_q;
    assign reg_fetch_ins = reg_fetch_ins_q;
    assign reg_fetch_pc  = reg_fetch_pc_q;
    assign fetch_err     = fetch_err_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model of the fetch stage.

module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_next;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        fetch_valid;
    logic [31:0] reg_fetch_ins;
    logic [63:0] reg_fetch_pc;
    logic        fetch_err;
    logic [63:0] fetch_count;

    // Bus responder state
    logic        resp_busy;
    int          resp_cnt;
    int          resp_delay;
    logic [31:0] resp_data;
    logic        random_mode;

    // Reference model: what the fetch stage has promised so far
    logic        m_outstanding;
    logic        m_discard;
    logic        m_holding;
    logic [63:0] m_next_pc;
    logic [63:0] m_bus_addr;
    logic [63:0] m_last_pc;
    logic [31:0] m_last_ins;
    logic        m_last_err;
    logic        m_pulse;
    logic [63:0] m_count;

    int check_count = 0;
    int fail_count  = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .fetch_next     (fetch_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .fetch_valid    (fetch_valid),
        .reg_fetch_ins  (reg_fetch_ins),
        .reg_fetch_pc   (reg_fetch_pc),
        .fetch_err      (fetch_err),
        .fetch_count    (fetch_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One clock: drive the bus response, clock the DUT, advance the model, compare.
    task automatic applyStimulus();
        logic        s_rst, s_stall, s_next, s_redir, s_ok;
        logic [63:0] s_rpc;
        logic [31:0] s_data;

        iresp_data_ok = 1'b0;
        if (!resp_busy && ireq_valid === 1'b1) begin
            resp_busy = 1'b1;
            if (random_mode) resp_delay = $urandom_range(1, 4);
            resp_cnt = resp_delay;
        end
        if (resp_busy) begin
            if (resp_cnt <= 1) begin
                iresp_data_ok = 1'b1;
                iresp_data    = resp_data;
                resp_busy     = 1'b0;
                if (random_mode) resp_data = $urandom;
            end else begin
                resp_cnt--;
            end
        end

        s_rst = rst; s_stall = stall; s_next = fetch_next; s_redir = redirect_valid;
        s_rpc = redirect_pc; s_ok = iresp_data_ok; s_data = iresp_data;

        @(posedge clk);
        #1;

        m_pulse = 1'b0;
        if (s_rst) begin
            m_outstanding = 1'b0; m_discard = 1'b0; m_holding = 1'b0;
            m_next_pc = RESET_PC; m_bus_addr = RESET_PC;
            m_last_pc = 64'd0; m_last_ins = NOP; m_last_err = 1'b0; m_count = 64'd0;
        end else if (m_outstanding) begin
            if (s_ok) begin
                m_outstanding = 1'b0;
                if (m_discard || s_redir) begin
                    m_discard = 1'b0;
                    if (s_redir) m_next_pc = s_rpc;
                end else begin
                    m_holding = 1'b1; m_pulse = 1'b1; m_count = m_count + 1;
                    m_last_pc = m_bus_addr; m_last_ins = s_data; m_last_err = 1'b0;
                end
            end else if (s_redir) begin
                m_next_pc = s_rpc;
                m_discard = 1'b1;
            end
        end else if (m_holding) begin
            if (s_redir) begin
                m_next_pc = s_rpc; m_holding = 1'b0;
            end else if (s_next) begin
                m_next_pc = m_last_pc + 64'd4; m_holding = 1'b0;
            end
        end else begin
            if (s_redir) begin
                m_next_pc = s_rpc;
            end else if (!s_stall) begin
                if (m_next_pc % 4 == 0) begin
                    m_outstanding = 1'b1; m_bus_addr = m_next_pc;
                end else begin
                    m_holding = 1'b1; m_pulse = 1'b1; m_count = m_count + 1;
                    m_last_pc = m_next_pc; m_last_ins = NOP; m_last_err = 1'b1;
                end
            end
        end

        checkOutput("ireq_valid", 64'(ireq_valid), 64'(m_outstanding));
        checkOutput("ireq_addr", ireq_addr, m_bus_addr);
        checkOutput("fetch_valid", 64'(fetch_valid), 64'(m_pulse));
        checkOutput("reg_fetch_pc", reg_fetch_pc, m_last_pc);
        checkOutput("reg_fetch_ins", 64'(reg_fetch_ins), 64'(m_last_ins));
        checkOutput("fetch_err", 64'(fetch_err), 64'(m_last_err));
        checkOutput("fetch_count", fetch_count, m_count);
    endtask

    task automatic waitFetch(input string tag, input int max_cycles);
        int n = 0;
        while (fetch_valid !== 1'b1 && n < max_cycles) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 64'(fetch_valid), 64'd1);
    endtask

    task automatic stepUntilAddr(input logic [63:0] addr, input int max_cycles, output logic saw_pulse);
        saw_pulse = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            applyStimulus();
            if (fetch_valid === 1'b1) saw_pulse = 1'b1;
            if (ireq_valid === 1'b1 && ireq_addr === addr) break;
        end
    endtask

    initial begin
        logic saw_pulse;

        rst = 1'b1; stall = 1'b0; fetch_next = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 64'd0; iresp_data_ok = 1'b0; iresp_data = 32'd0;
        resp_busy = 1'b0; resp_cnt = 0; resp_delay = 3; resp_data = 32'h0050_0093;
        random_mode = 1'b0;
        m_outstanding = 1'b0; m_discard = 1'b0; m_holding = 1'b0;
        m_next_pc = RESET_PC; m_bus_addr = RESET_PC; m_last_pc = 64'd0;
        m_last_ins = NOP; m_last_err = 1'b0; m_pulse = 1'b0; m_count = 64'd0;

        applyStimulus();
        applyStimulus();
        checkOutput("reset_ireq_valid", 64'(ireq_valid), 64'd0);
        checkOutput("reset_ins", 64'(reg_fetch_ins), 64'h13);
        checkOutput("reset_pc", reg_fetch_pc, 64'd0);
        checkOutput("reset_count", fetch_count, 64'd0);

        rst = 1'b0;
        applyStimulus();
        checkOutput("first_req_valid", 64'(ireq_valid), 64'd1);
        checkOutput("first_req_addr", ireq_addr, 64'h8000_0000);

        waitFetch("fetch1_timeout", 10);
        checkOutput("fetch1_pc", reg_fetch_pc, 64'h8000_0000);
        checkOutput("fetch1_ins", 64'(reg_fetch_ins), 64'h0050_0093);
        checkOutput("fetch1_count", fetch_count, 64'd1);
        applyStimulus();
        checkOutput("fetch1_pulse_width", 64'(fetch_valid), 64'd0);

        fetch_next = 1'b1;
        applyStimulus();
        fetch_next = 1'b0;
        applyStimulus();
        checkOutput("seq_req_valid", 64'(ireq_valid), 64'd1);
        checkOutput("seq_req_addr", ireq_addr, 64'h8000_0004);

        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        applyStimulus();
        redirect_valid = 1'b0;
        stepUntilAddr(64'h8000_0100, 12, saw_pulse);
        checkOutput("kill_no_pulse", 64'(saw_pulse), 64'd0);
        checkOutput("kill_req_addr", ireq_addr, 64'h8000_0100);
        checkOutput("kill_count", fetch_count, 64'd1);

        waitFetch("fetch2_timeout", 10);
        checkOutput("fetch2_count", fetch_count, 64'd2);

        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; fetch_next = 1'b1;
        applyStimulus();
        redirect_valid = 1'b0; fetch_next = 1'b0;
        applyStimulus();
        checkOutput("redir_wins_addr", ireq_addr, 64'h8000_0200);
        waitFetch("fetch3_timeout", 10);

        fetch_next = 1'b1; stall = 1'b1;
        applyStimulus();
        fetch_next = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stall_idle_valid", 64'(ireq_valid), 64'd0);
        end
        stall = 1'b0;
        applyStimulus();
        checkOutput("post_stall_addr", ireq_addr, 64'h8000_0204);
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            if (fetch_valid === 1'b1) break;
            checkOutput("stall_req_valid", 64'(ireq_valid), 64'd1);
            checkOutput("stall_req_addr", ireq_addr, 64'h8000_0204);
        end
        checkOutput("stall_req_delivered", 64'(fetch_valid), 64'd1);
        stall = 1'b0;

        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        applyStimulus();
        redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("mis_pulse", 64'(fetch_valid), 64'd1);
        checkOutput("mis_err", 64'(fetch_err), 64'd1);
        checkOutput("mis_pc", reg_fetch_pc, 64'h8000_0102);
        checkOutput("mis_ins", 64'(reg_fetch_ins), 64'h13);
        checkOutput("mis_no_req", 64'(ireq_valid), 64'd0);
        checkOutput("mis_count", fetch_count, 64'd5);

        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        applyStimulus();
        redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("rst_mid_req_addr", ireq_addr, 64'h8000_0300);
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("late_resp_no_pulse", 64'(fetch_valid), 64'd0);
        checkOutput("after_rst_addr", ireq_addr, RESET_PC);
        checkOutput("after_rst_count", fetch_count, 64'd0);

        random_mode = 1'b1;
        resp_data = $urandom;
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom % 250 == 0);
            stall          = ($urandom % 4 == 0);
            fetch_next     = ($urandom % 3 == 0);
            redirect_valid = ($urandom % 10 == 0);
            case ($urandom % 8)
                0:       redirect_pc = 64'h8000_0000 + 64'($urandom % 64);
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
                default: redirect_pc = 64'h8000_0000 + 64'(($urandom % 256) * 4);
            endcase
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
